butterfly_pipe: RTL and testbench

Fully pipelined, parametrised radix-2 FFT butterfly computing YA = XA + W·XB and YB = XA − W·XB. It accepts a new sample every cycle and has per-sample inverse-FFT (conjugate twiddle) and divide-by-2 scaling controls. Outputs use rounded fixed-point arithmetic with saturation, and a sticky overflow flag reports any clipping. It sits in each FFT stage between the twiddle ROM and the stage reorder buffer.

---
 rtl/butterfly_pipe.sv | 187 ++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// Radix-2 FFT butterfly: ya = xa + w*xb, yb = xa - w*xb.
// Four-stage pipeline with one sample per cycle and optional twiddle conjugation.
// Outputs use rounding, optional divide-by-2 and saturation.
// A sticky ovf flag records any clipped output component.
module butterfly_pipe #(
    parameter int DW     = 16,
    parameter int TW     = 16,
    parameter int MWIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                inverse,
    input  logic                scale,
    input  logic [MWIDTH-1:0]   m_in,
    input  logic [2*TW-1:0]     w,
    input  logic [2*DW-1:0]     xa,
    input  logic [2*DW-1:0]     xb,
    input  logic                ovf_clr,
    output logic                out_valid,
    output logic [MWIDTH-1:0]   m_out,
    output logic [2*DW-1:0]     ya,
    output logic [2*DW-1:0]     yb,
    output logic                ovf
);

    localparam int PW = DW + TW;       // single product
    localparam int SW = DW + TW + 1;   // sum of two products
    localparam int RW = DW + 2;        // rounded, rescaled product
    localparam int AW = DW + 3;        // butterfly sum

    localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [SW-1:0] RND   = SW'(2 ** (TW - 3));
    localparam logic signed [AW-1:0] SMAX  = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN  = ~SMAX;
    localparam logic signed [DW-1:0] YMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] YMIN  = {1'b1, {(DW-1){1'b0}}};

    // Stage 1 registers
    logic                      v1_q, sc1_q;
    logic [MWIDTH-1:0]         m1_q;
    logic signed [DW-1:0]      xa_re1_q, xa_im1_q, xb_re1_q, xb_im1_q;
    logic signed [TW-1:0]      w_re1_q, w_im1_q;
    logic signed [TW-1:0]      w_im_d;
    // Stage 2 registers
    logic                      v2_q, sc2_q;
    logic [MWIDTH-1:0]         m2_q;
    logic signed [DW-1:0]      xa_re2_q, xa_im2_q;
    logic signed [PW-1:0]      prr_q, pii_q, pri_q, pir_q;
    // Stage 3 registers
    logic                      v3_q, sc3_q;
    logic [MWIDTH-1:0]         m3_q;
    logic signed [DW-1:0]      xa_re3_q, xa_im3_q;
    logic signed [RW-1:0]      p_re3_q, p_im3_q;
    logic signed [SW-1:0]      pre_d, pim_d;
    logic signed [RW-1:0]      p_re3_d, p_im3_d;
    // Stage 4 registers
    logic                      out_valid_q, ovf_q;
    logic [MWIDTH-1:0]         m_out_q;
    logic [2*DW-1:0]           ya_q, yb_q;
    logic signed [AW-1:0]      s_ar_d, s_ai_d, s_br_d, s_bi_d;
    logic                      sat_d;

    function automatic logic signed [AW-1:0] halve(input logic signed [AW-1:0] s,
                                                   input logic en);
        if (en) halve = (s + AW'(1)) >>> 1;
        else    halve = s;
    endfunction

    function automatic logic is_sat(input logic signed [AW-1:0] s);
        is_sat = (s > SMAX) || (s < SMIN);
    endfunction

    function automatic logic signed [DW-1:0] clamp(input logic signed [AW-1:0] s);
        if (s > SMAX)      clamp = YMAX;
        else if (s < SMIN) clamp = YMIN;
        else               clamp = DW'(s);
    endfunction

    // Conjugate the twiddle imaginary part; the most negative value clips to max.
    always_comb begin
        w_im_d = w[TW-1:0];
        if (inverse) begin
            if (w[TW-1:0] == W_MIN) w_im_d = W_MAX;
            else                    w_im_d = -$signed(w[TW-1:0]);
        end
    end

    // S1: register operands, twiddle and per-sample controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; sc1_q <= 1'b0; m1_q <= '0;
            xa_re1_q <= '0; xa_im1_q <= '0; xb_re1_q <= '0; xb_im1_q <= '0;
            w_re1_q <= '0; w_im1_q <= '0;
        end else begin
            v1_q     <= in_valid;
            sc1_q    <= scale;
            m1_q     <= m_in;
            xa_re1_q <= xa[2*DW-1:DW];
            xa_im1_q <= xa[DW-1:0];
            xb_re1_q <= xb[2*DW-1:DW];
            xb_im1_q <= xb[DW-1:0];
            w_re1_q  <= w[2*TW-1:TW];
            w_im1_q  <= w_im_d;
        end
    end

    // S2: the four partial products; xa follows in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0; sc2_q <= 1'b0; m2_q <= '0;
            xa_re2_q <= '0; xa_im2_q <= '0;
            prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
        end else begin
            v2_q     <= v1_q;
            sc2_q    <= sc1_q;
            m2_q     <= m1_q;
            xa_re2_q <= xa_re1_q;
            xa_im2_q <= xa_im1_q;
            prr_q    <= PW'(xb_re1_q) * PW'(w_re1_q);
            pii_q    <= PW'(xb_im1_q) * PW'(w_im1_q);
            pri_q    <= PW'(xb_re1_q) * PW'(w_im1_q);
            pir_q    <= PW'(xb_im1_q) * PW'(w_re1_q);
        end
    end

    // Complex product, rounded half up and rescaled from Q2.(TW-2).
    always_comb begin
        pre_d   = SW'(prr_q) - SW'(pii_q);
        pim_d   = SW'(pri_q) + SW'(pir_q);
        p_re3_d = RW'((pre_d + RND) >>> (TW - 2));
        p_im3_d = RW'((pim_d + RND) >>> (TW - 2));
    end

    // S3: register the rescaled product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q <= 1'b0; sc3_q <= 1'b0; m3_q <= '0;
            xa_re3_q <= '0; xa_im3_q <= '0; p_re3_q <= '0; p_im3_q <= '0;
        end else begin
            v3_q     <= v2_q;
            sc3_q    <= sc2_q;
            m3_q     <= m2_q;
            xa_re3_q <= xa_re2_q;
            xa_im3_q <= xa_im2_q;
            p_re3_q  <= p_re3_d;
            p_im3_q  <= p_im3_d;
        end
    end

    // Butterfly sums with optional halving; any clipping of a valid sample flags ovf.
    always_comb begin
        s_ar_d = halve(AW'(xa_re3_q) + AW'(p_re3_q), sc3_q);
        s_ai_d = halve(AW'(xa_im3_q) + AW'(p_im3_q), sc3_q);
        s_br_d = halve(AW'(xa_re3_q) - AW'(p_re3_q), sc3_q);
        s_bi_d = halve(AW'(xa_im3_q) - AW'(p_im3_q), sc3_q);
        sat_d  = v3_q & (is_sat(s_ar_d) | is_sat(s_ai_d) | is_sat(s_br_d) | is_sat(s_bi_d));
    end

    // S4: saturate into the outputs, which hold between valid samples; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            m_out_q     <= '0;
            ya_q        <= '0;
            yb_q        <= '0;
        end else begin
            out_valid_q <= v3_q;
            if (v3_q) begin
                m_out_q <= m3_q;
                ya_q    <= {clamp(s_ar_d), clamp(s_ai_d)};
                yb_q    <= {clamp(s_br_d), clamp(s_bi_d)};
            end
            if (sat_d)        ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign m_out     = m_out_q;
    assign ya        = ya_q;
    assign yb        = yb_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed cases plus a random stream
// compared against an arithmetic reference model with a queue of expected outputs.
module tb_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;
    localparam int MW = 5;

    logic              clk = 1'b0;
    logic              rst, in_valid, inverse, scale, ovf_clr;
    logic [MW-1:0]     m_in;
    logic [2*TW-1:0]   w;
    logic [2*DW-1:0]   xa, xb;
    logic              out_valid, ovf;
    logic [MW-1:0]     m_out;
    logic [2*DW-1:0]   ya, yb;

    int n_chk = 0;
    int n_err = 0;

    butterfly_pipe #(.DW(DW), .TW(TW), .MWIDTH(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse), .scale(scale),
        .m_in(m_in), .w(w), .xa(xa), .xb(xb), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .m_out(m_out), .ya(ya), .yb(yb), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [2*DW-1:0] ya;
        logic [2*DW-1:0] yb;
        logic [MW-1:0]   m;
        int              due;
        bit              sat;
    } exp_t;

    function automatic longint wrap(input longint v, input int bits);
        longint md, r;
        md = longint'(1) <<< bits;
        r  = v & (md - 1);
        if (r >= (md >>> 1)) r = r - md;
        return r;
    endfunction

    // Reference butterfly in plain integer arithmetic.
    function automatic exp_t model(input bit inv, input bit sc, input logic [MW-1:0] m,
                                   input logic [2*TW-1:0] wv, input logic [2*DW-1:0] a,
                                   input logic [2*DW-1:0] b);
        exp_t e;
        longint wr, wi, ar, ai, br, bi, pr, pi, lim;
        longint s[4];
        logic [DW-1:0] r[4];
        wr = longint'($signed(wv[2*TW-1:TW]));
        wi = longint'($signed(wv[TW-1:0]));
        ar = longint'($signed(a[2*DW-1:DW]));
        ai = longint'($signed(a[DW-1:0]));
        br = longint'($signed(b[2*DW-1:DW]));
        bi = longint'($signed(b[DW-1:0]));
        if (inv) begin
            if (wi == -(longint'(1) <<< (TW - 1))) wi = (longint'(1) <<< (TW - 1)) - 1;
            else                                   wi = -wi;
        end
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        pr = wrap((pr + (longint'(1) <<< (TW - 3))) >>> (TW - 2), DW + 2);
        pi = wrap((pi + (longint'(1) <<< (TW - 3))) >>> (TW - 2), DW + 2);
        s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
        lim = longint'(1) <<< (DW - 1);
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = (s[k] + 1) >>> 1;
            if (s[k] > lim - 1) begin s[k] = lim - 1; e.sat = 1'b1; end
            else if (s[k] < -lim) begin s[k] = -lim; e.sat = 1'b1; end
            r[k] = s[k][DW-1:0];
        end
        e.ya  = {r[0], r[1]};
        e.yb  = {r[2], r[3]};
        e.m   = m;
        e.due = 0;
        return e;
    endfunction

    // Expected output state, advanced on every rising edge from the sampled inputs.
    exp_t            q[$];
    int              edge_cnt = 0;
    logic            exp_ov   = 1'b0;
    logic            exp_ovf  = 1'b0;
    logic [2*DW-1:0] exp_ya   = '0;
    logic [2*DW-1:0] exp_yb   = '0;
    logic [MW-1:0]   exp_m    = '0;

    always @(posedge clk) begin
        exp_t e;
        bit   set;
        edge_cnt++;
        if (rst) begin
            q.delete();
            exp_ov = 1'b0; exp_ovf = 1'b0;
            exp_ya = '0; exp_yb = '0; exp_m = '0;
        end else begin
            set    = 1'b0;
            exp_ov = 1'b0;
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                e      = q.pop_front();
                exp_ov = 1'b1;
                exp_ya = e.ya;
                exp_yb = e.yb;
                exp_m  = e.m;
                set    = e.sat;
            end
            if (set)          exp_ovf = 1'b1;
            else if (ovf_clr) exp_ovf = 1'b0;
            if (in_valid) begin
                e     = model(inverse, scale, m_in, w, xa, xb);
                e.due = edge_cnt + 3;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        check("ya", {32'd0, ya}, {32'd0, exp_ya});
        check("yb", {32'd0, yb}, {32'd0, exp_yb});
        check("m_out", {59'd0, m_out}, {59'd0, exp_m});
        check("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
    end

    task automatic drive(input bit iv, input bit inv, input bit sc, input logic [MW-1:0] m,
                         input int wr, input int wi, input int ar, input int ai,
                         input int br, input int bi);
        in_valid = iv; inverse = inv; scale = sc; m_in = m;
        w  = {TW'(wr), TW'(wi)};
        xa = {DW'(ar), DW'(ai)};
        xb = {DW'(br), DW'(bi)};
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; inverse = 1'b0; scale = 1'b0; ovf_clr = 1'b0;
        m_in = '0; w = '0; xa = '0; xb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ya", {32'd0, ya}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);

        // Unit twiddle
        drive(1, 0, 0, 5'd1, 16384, 0, 100, 50, 20, -10);
        idle(3);
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_ya", {32'd0, ya}, {32'd0, 16'd120, 16'd40});
        check("t1_yb", {32'd0, yb}, {32'd0, 16'd80, 16'd60});
        check("t1_m", {59'd0, m_out}, 64'd1);
        idle(1);
        check("t1_pulse", {63'd0, out_valid}, 64'd0);
        check("t1_hold", {32'd0, ya}, {32'd0, 16'd120, 16'd40});

        // Twiddle j, forward then conjugated
        drive(1, 0, 0, 5'd2, 0, 16384, 100, 50, 20, -10);
        drive(1, 1, 0, 5'd3, 0, 16384, 100, 50, 20, -10);
        idle(2);
        check("t2_fwd_ya", {32'd0, ya}, {32'd0, 16'd110, 16'd70});
        check("t2_fwd_yb", {32'd0, yb}, {32'd0, 16'd90, 16'd30});
        idle(1);
        check("t2_inv_ya", {32'd0, ya}, {32'd0, 16'd90, 16'd30});
        check("t2_inv_yb", {32'd0, yb}, {32'd0, 16'd110, 16'd70});

        // Halving with round half up
        drive(1, 0, 1, 5'd4, 16384, 0, 101, -101, 0, 0);
        drive(1, 0, 1, 5'd5, 16384, 0, 3, 0, 0, 0);
        idle(2);
        check("t3_ya", {32'd0, ya}, {32'd0, 16'd51, 16'hFFCE});
        check("t3_yb", {32'd0, yb}, {32'd0, 16'd51, 16'hFFCE});
        idle(1);
        check("t3b_ya", {32'd0, ya}, {32'd0, 16'd2, 16'd0});
        check("t3_no_ovf", {63'd0, ovf}, 64'd0);

        // Saturation, unscaled then scaled
        drive(1, 0, 0, 5'd6, 16384, 0, 30000, -30000, 30000, -30000);
        idle(3);
        check("t4_ya", {32'd0, ya}, {32'd0, 16'h7FFF, 16'h8000});
        check("t4_yb", {32'd0, yb}, 64'd0);
        check("t4_ovf", {63'd0, ovf}, 64'd1);
        drive(1, 0, 1, 5'd7, 16384, 0, 30000, -30000, 30000, -30000);
        idle(3);
        check("t5_ya", {32'd0, ya}, {32'd0, 16'd30000, 16'h8AD0});
        check("t5_yb", {32'd0, yb}, 64'd0);
        check("t5_ovf_sticky", {63'd0, ovf}, 64'd1);

        // ovf clear alone, then clear colliding with a new saturation
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        check("t6_clr", {63'd0, ovf}, 64'd0);
        drive(1, 0, 0, 5'd8, 16384, 0, 30000, -30000, 30000, -30000);
        idle(2);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        check("t6_set_wins", {63'd0, ovf}, 64'd1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        check("t6_clr2", {63'd0, ovf}, 64'd0);

        // Conjugating the most negative twiddle imaginary part
        drive(1, 1, 0, 5'd9, 16384, -32768, 1000, -1000, 1000, 1000);
        idle(4);

        // Random stream with gaps and a mid-stream reset
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), MW'(i),
                  rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
            if (i == 10) begin
                rst = 1'b1; idle(1); rst = 1'b0;
                check("rst_flush_ovf", {63'd0, ovf}, 64'd0);
            end
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
